// File: rtl/hc595_frame_rx_pkg.sv
// rtl/hc595_frame_rx_pkg.sv - shared frame layout, segment table and FSM types for the 74HC595 link
package hc595_frame_rx_pkg;

    localparam int FRAME_W = 16;
    localparam int DP_BIT  = 15;
    localparam int SEG_MSB = 14;
    localparam int SEG_LSB = 8;
    localparam int FMT_MSB = 7;
    localparam int FMT_LSB = 4;
    localparam int SEL_MSB = 3;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [4:0] BIT_CNT_MAX = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL,
        ST_OVER
    } state_t;

    // Active-low {g,f,e,d,c,b,a}; the transmit-side encoder uses the same table.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        case (val)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    function automatic state_t state_of(input logic [4:0] cnt);
        if (cnt == 5'd0)
            state_of = ST_IDLE;
        else if (cnt < 5'd16)
            state_of = ST_SHIFT;
        else if (cnt == 5'd16)
            state_of = ST_FULL;
        else
            state_of = ST_OVER;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - inverse of the hex-to-segment table; hit=0 for any non-hex pattern
module seg7_hex_decode
    import hc595_frame_rx_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_hit,
    output logic [3:0] o_val
);

    always_comb begin
        o_hit = 1'b0;
        o_val = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == hex_to_seg(4'(i))) begin
                o_hit = 1'b1;
                o_val = 4'(i);
            end
        end
    end

endmodule

// File: rtl/hc595_frame_rx.sv
// rtl/hc595_frame_rx.sv - receive side of the 3-wire 74HC595 display link with 4-digit buffer
module hc595_frame_rx
    import hc595_frame_rx_pkg::*;
#(
    parameter bit SEL_ACTIVE_LOW = 1'b0,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sh_cp,
    input  logic        st_cp,
    input  logic        ds,
    input  logic        clr_err,
    output logic        frame_valid,
    output logic [3:0]  digit_val,
    output logic [1:0]  digit_pos,
    output logic        dp,
    output logic [15:0] disp_data,
    output logic [3:0]  err_pulse,
    output logic [3:0]  err_sticky
);

    // Index SYNC_STAGES-1 is the newest synchronized sample, index SYNC_STAGES the history flop.
    logic [SYNC_STAGES:0]   r_sh_sync;
    logic [SYNC_STAGES:0]   r_st_sync;
    logic [SYNC_STAGES-1:0] r_ds_sync;

    logic [FRAME_W-1:0] r_shreg;
    logic [4:0]         r_bit_cnt;
    state_t             r_state;

    logic       w_sh_edge;
    logic       w_st_edge;
    logic       w_ds;
    logic [3:0] w_sel;
    logic       w_sel_onehot;
    logic [1:0] w_pos;
    logic       w_hit;
    logic [3:0] w_val;
    logic [3:0] w_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_sync <= '0;
            r_st_sync <= '0;
            r_ds_sync <= '0;
        end else begin
            r_sh_sync <= {r_sh_sync[SYNC_STAGES-1:0], sh_cp};
            r_st_sync <= {r_st_sync[SYNC_STAGES-1:0], st_cp};
            r_ds_sync <= {r_ds_sync[SYNC_STAGES-2:0], ds};
        end
    end

    assign w_sh_edge = r_sh_sync[SYNC_STAGES-1] & ~r_sh_sync[SYNC_STAGES];
    assign w_st_edge = r_st_sync[SYNC_STAGES-1] & ~r_st_sync[SYNC_STAGES];
    assign w_ds      = r_ds_sync[SYNC_STAGES-1];

    assign w_sel        = SEL_ACTIVE_LOW ? ~r_shreg[SEL_MSB:0] : r_shreg[SEL_MSB:0];
    assign w_sel_onehot = (w_sel != 4'h0) && ((w_sel & (w_sel - 4'h1)) == 4'h0);

    always_comb begin
        w_pos = 2'd0;
        case (w_sel)
            4'b0010: w_pos = 2'd1;
            4'b0100: w_pos = 2'd2;
            4'b1000: w_pos = 2'd3;
            default: w_pos = 2'd0;
        endcase
    end

    seg7_hex_decode u_seg7_hex_decode (
        .i_seg (r_shreg[SEG_MSB:SEG_LSB]),
        .o_hit (w_hit),
        .o_val (w_val)
    );

    assign w_err = {r_shreg[FMT_MSB:FMT_LSB] != 4'h0, ~w_hit, ~w_sel_onehot, r_state != ST_FULL};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_state     <= ST_IDLE;
            frame_valid <= 1'b0;
            digit_val   <= '0;
            digit_pos   <= '0;
            dp          <= 1'b0;
            disp_data   <= '0;
            err_pulse   <= '0;
            err_sticky  <= '0;
        end else begin
            frame_valid <= 1'b0;
            err_pulse   <= '0;
            if (clr_err)
                err_sticky <= '0;

            if (w_sh_edge)
                r_shreg <= {r_shreg[FRAME_W-2:0], w_ds};

            // The latch checks the pre-shift register, so a coincident shift starts the next frame.
            if (w_st_edge) begin
                r_bit_cnt <= w_sh_edge ? 5'd1 : 5'd0;
                r_state   <= w_sh_edge ? ST_SHIFT : ST_IDLE;
                if (w_err == 4'h0) begin
                    frame_valid                 <= 1'b1;
                    digit_val                   <= w_val;
                    digit_pos                   <= w_pos;
                    dp                          <= r_shreg[DP_BIT];
                    disp_data[{w_pos, 2'b00} +: 4] <= w_val;
                end else begin
                    err_pulse  <= w_err;
                    err_sticky <= (clr_err ? 4'h0 : err_sticky) | w_err;
                end
            end else if (w_sh_edge && r_bit_cnt != BIT_CNT_MAX) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
                r_state   <= state_of(r_bit_cnt + 5'd1);
            end
        end
    end

endmodule

// File: tb/tb_hc595_frame_rx.sv
// tb/tb_hc595_frame_rx.sv - directed self-checking bench for hc595_frame_rx
module tb_hc595_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sh_cp = 1'b0;
    logic        st_cp = 1'b0;
    logic        ds = 1'b0;
    logic        clr_err = 1'b0;
    logic        frame_valid;
    logic [3:0]  digit_val;
    logic [1:0]  digit_pos;
    logic        dp;
    logic [15:0] disp_data;
    logic [3:0]  err_pulse;
    logic [3:0]  err_sticky;

    int n_vec = 0;
    int n_err = 0;

    int         fv_cnt;
    int         fv_idx;
    int         err_cycles;
    logic [3:0] err_seen;

    hc595_frame_rx #(
        .SEL_ACTIVE_LOW (1'b0),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sh_cp       (sh_cp),
        .st_cp       (st_cp),
        .ds          (ds),
        .clr_err     (clr_err),
        .frame_valid (frame_valid),
        .digit_val   (digit_val),
        .digit_pos   (digit_pos),
        .dp          (dp),
        .disp_data   (disp_data),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        ds = b;
        wait_clk(2);
        sh_cp = 1'b1;
        wait_clk(3);
        sh_cp = 1'b0;
        wait_clk(2);
    endtask

    task automatic shift_bits(input logic [15:0] f, input int n);
        for (int i = n - 1; i >= 0; i--)
            shift_bit(f[i]);
    endtask

    task automatic observe(input int n);
        fv_cnt     = 0;
        fv_idx     = -1;
        err_cycles = 0;
        err_seen   = 4'h0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (frame_valid) begin
                fv_cnt++;
                if (fv_idx < 0) fv_idx = k;
            end
            if (err_pulse != 4'h0) err_cycles++;
            err_seen |= err_pulse;
        end
    endtask

    task automatic latch();
        st_cp = 1'b1;
        observe(6);
        st_cp = 1'b0;
        wait_clk(3);
    endtask

    task automatic latch_with_shift(input logic b);
        ds = b;
        wait_clk(2);
        sh_cp = 1'b1;
        st_cp = 1'b1;
        observe(6);
        sh_cp = 1'b0;
        st_cp = 1'b0;
        wait_clk(3);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        wait_clk(1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(2);
    endtask

    initial begin
        wait_clk(3);
        chk("reset_outputs", {frame_valid, digit_val, digit_pos, dp, disp_data, err_pulse, err_sticky}, 32'h0);
        rst = 1'b1;
        wait_clk(2);

        // Digit 0 at position 0.
        shift_bits(16'h4001, 16);
        latch();
        chk("f4001_fv_cnt", fv_cnt, 1);
        chk("f4001_latency", fv_idx, 2);
        chk("f4001_err", err_seen, 4'h0);
        chk("f4001_val_pos_dp", {digit_val, digit_pos, dp}, {4'h0, 2'd0, 1'b0});
        chk("f4001_disp", disp_data, 16'h0000);

        // Two digits into a fresh buffer.
        do_reset();
        shift_bits(16'h3002, 16);
        latch();
        chk("f3002_fv_cnt", fv_cnt, 1);
        chk("f3002_val_pos", {digit_val, digit_pos}, {4'h3, 2'd1});
        shift_bits(16'h7808, 16);
        latch();
        chk("f7808_val_pos", {digit_val, digit_pos}, {4'h7, 2'd3});
        chk("f7808_disp", disp_data, 16'h7030);
        chk("f7808_sticky", err_sticky, 4'h0);

        // Short frame: shreg still ends up holding 16'h4001, only the length is wrong.
        shift_bits(16'h4001, 15);
        latch();
        chk("short_err", err_seen, 4'b0001);
        chk("short_err_width", err_cycles, 1);
        chk("short_fv", fv_cnt, 0);
        chk("short_disp", disp_data, 16'h7030);
        chk("short_sticky", err_sticky, 4'b0001);

        latch();
        chk("noshift_err", err_seen, 4'b0001);
        chk("noshift_disp", disp_data, 16'h7030);

        shift_bit(1'b1);
        shift_bits(16'h4001, 16);
        latch();
        chk("long_err", err_seen, 4'b0001);
        chk("long_fv", fv_cnt, 0);
        chk("long_disp", disp_data, 16'h7030);

        pulse_clr();
        chk("clr_sticky_len", err_sticky, 4'h0);

        // Blank segments with two sel bits set.
        shift_bits(16'h7F03, 16);
        latch();
        chk("blank_err", err_seen, 4'b0110);
        chk("blank_fv", fv_cnt, 0);
        chk("blank_sticky", err_sticky, 4'b0110);
        chk("blank_disp", disp_data, 16'h7030);
        pulse_clr();
        chk("clr_sticky_blank", err_sticky, 4'h0);

        // Coincident latch and shift: the shift is bit 15 of the next frame.
        shift_bits(16'h2404, 16);
        latch_with_shift(1'b0);
        chk("coinc_fv", fv_cnt, 1);
        chk("coinc_err", err_seen, 4'h0);
        chk("coinc_val_pos", {digit_val, digit_pos}, {4'h2, 2'd2});
        chk("coinc_disp", disp_data, 16'h7230);
        chk("coinc_bit_cnt", dut.r_bit_cnt, 5'd1);
        shift_bits(16'h1904, 15);
        latch();
        chk("after_coinc_fv", fv_cnt, 1);
        chk("after_coinc_disp", disp_data, 16'h7430);

        // Reset in the middle of a frame.
        shift_bits(16'h8E01, 8);
        rst = 1'b0;
        wait_clk(2);
        chk("midreset_outputs", {frame_valid, digit_val, digit_pos, dp, disp_data, err_pulse, err_sticky}, 32'h0);
        rst = 1'b1;
        wait_clk(2);
        shift_bits(16'h8E01, 16);
        latch();
        chk("postreset_fv", fv_cnt, 1);
        chk("postreset_err", err_seen, 4'h0);
        chk("postreset_val_pos_dp", {digit_val, digit_pos, dp}, {4'hF, 2'd0, 1'b1});
        chk("postreset_disp", disp_data, 16'h000F);
        chk("postreset_sticky", err_sticky, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
